ro_capture: RTL

// - Downstream consumer of the shared readout lines driven by the per-channel ro_block tristate stages.
// - Tracks the gray count that schedules those stages and identifies the channel owning the bus each cycle

---
 rtl/ro_capture.sv | 125 ++++++++++++
 1 files changed

// File: rtl/ro_capture.sv
// ro_capture: tags single-bit gray-count transitions with the owning readout channel and queues events.
// Optional feature macro RO_CAPTURE_TIMESTAMP_EN adds a free-running timestamp to each queued entry.
module ro_capture #(
   parameter int GC_W       = 19,
   parameter int CH_W       = 5,
   parameter int FIFO_DEPTH = 16,
   parameter int PUSH_ZEROS = 0,
   parameter int TS_W       = 16,
   localparam int AW        = $clog2(FIFO_DEPTH),
`ifdef RO_CAPTURE_TIMESTAMP_EN
   localparam int DW        = TS_W + CH_W + 2
`else
   localparam int DW        = CH_W + 2
`endif
) (
   input  logic            clk_master,
   input  logic            reset,
   input  logic [GC_W-1:0] gray_count,
   input  logic            readout_eve,
   input  logic            readout_pol_eve,
   input  logic [GC_W-1:0] chan_mask,
   input  logic            out_ready,
   output logic            out_valid,
   output logic [DW-1:0]   out_data,
   output logic [AW:0]     fifo_level,
   output logic            overflow,
   output logic            slot_err,
   input  logic            clear_flags
);

   if (CH_W < $clog2(GC_W + 1)) begin : g_bad_ch_w
      $error("CH_W too narrow for channel index GC_W");
   end
   if ((FIFO_DEPTH < 2) || ((1 << AW) != FIFO_DEPTH)) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of 2 and >= 2");
   end
   if (TS_W < 1) begin : g_bad_ts_w
      $error("TS_W must be >= 1");
   end

   logic [GC_W-1:0] gray_prev;
   logic [GC_W-1:0] diff;
   logic            primed;
   logic            one_hot;
   logic            multi;
   logic            slot_valid;
   logic            push_req;
   logic            push_ok;
   logic            pop;
   logic            full;
   logic [CH_W-1:0] bit_idx;
   logic [CH_W-1:0] ch_idx;
   logic [DW-1:0]   entry;
   logic [DW-1:0]   mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;

   assign diff    = gray_count ^ gray_prev;
   // x & (x-1) clears the lowest set bit, so zero here means exactly one bit toggled
   assign one_hot = (diff != '0) && ((diff & (diff - GC_W'(1))) == '0);
   assign multi   = (diff != '0) && !one_hot;

   always_comb begin
      bit_idx = '0;
      for (int i = 0; i < GC_W; i++) begin
         if (diff[i]) bit_idx = CH_W'(i);
      end
   end

   assign ch_idx     = bit_idx + CH_W'(1);
   assign slot_valid = primed && one_hot && ((diff & chan_mask) != '0);
   assign push_req   = slot_valid && ((PUSH_ZEROS != 0) || readout_eve || readout_pol_eve);

   assign out_valid = (fifo_level != '0);
   assign full      = (fifo_level == (AW+1)'(FIFO_DEPTH));
   assign pop       = out_valid && out_ready;
   assign push_ok   = push_req && (!full || pop);
   assign out_data  = out_valid ? mem[rd_ptr] : '0;

`ifdef RO_CAPTURE_TIMESTAMP_EN
   logic [TS_W-1:0] ts;

   always_ff @(posedge clk_master) begin
      if (reset) ts <= '0;
      else       ts <= ts + TS_W'(1);
   end

   assign entry = {ts, ch_idx, readout_pol_eve, readout_eve};
`else
   assign entry = {ch_idx, readout_pol_eve, readout_eve};
`endif

   always_ff @(posedge clk_master) begin
      if (reset) begin
         gray_prev  <= '0;
         primed     <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         overflow   <= 1'b0;
         slot_err   <= 1'b0;
      end else begin
         gray_prev <= gray_count;
         primed    <= 1'b1;
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop})
            2'b10:   fifo_level <= fifo_level + (AW+1)'(1);
            2'b01:   fifo_level <= fifo_level - (AW+1)'(1);
            default: fifo_level <= fifo_level;
         endcase
         // a same-cycle set wins over clear_flags
         if (primed && multi)            slot_err <= 1'b1;
         else if (clear_flags)           slot_err <= 1'b0;
         if (push_req && full && !pop)   overflow <= 1'b1;
         else if (clear_flags)           overflow <= 1'b0;
      end
   end

   // storage is not reset; out_data is gated by out_valid instead
   always_ff @(posedge clk_master) begin
      if (push_ok && !reset) mem[wr_ptr] <= entry;
   end

endmodule
